rsa_msg_sequencer: RTL
======================

# rsa_msg_sequencer

Upstream feeder for the RSA core. It accepts a byte stream over a valid/ready handshake and buffers it in a small FIFO. Each byte is range-checked against the modulus. The block then issues one `start` pulse per message to the core, waits for `finish` (with a timeout), and presents each result, tagged with an error flag, on a one-entry output register with valid/ready. Key and modulus inputs of the core are wired directly at the top level; this block drives only `msg_i`, `start_i`, `eORd` and consumes `msg_o` and `finish`.

## Interface
- WIDTH_N, 8, modulus and result width
- WIDTH_MSG_I, 8, message width
- FIFO_DEPTH, 4, input FIFO entries, power of two, ≥2
- TIMEOUT, 1023, max cycles waited for `core_finish`; counter width is clog2(TIMEOUT+1)
- GAP, 2, idle cycles enforced between `core_finish` and the next `core_start`
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low reset
- n_i  input  WIDTH_N  modulus, static while not idle
- s_data  input  WIDTH_MSG_I  message byte
- s_mode  input  1  1 = encrypt, 0 = decrypt (becomes `core_eORd`)
- s_valid  input  1  upstream data valid
- s_ready  output  1  FIFO not full
- core_msg  output  WIDTH_MSG_I  to core `msg_i`, registered
- core_eORd  output  1  to core `eORd`, registered
- core_start  output  1  one-cycle start pulse to core
- core_result  input  WIDTH_N  from core `msg_o`
- core_finish  input  1  from core, level or pulse
- m_data  output  WIDTH_N  result
- m_err  output  1  1 = range error or timeout; `m_data` = 0
- m_valid  output  1  result valid
- m_ready  input  1  downstream accept

## Operation
- FIFO stores {s_mode, s_data}. A write occurs when s_valid && s_ready.
- s_ready = !full. There is no write-on-full even when a pop happens in the same cycle.
- A pop into an empty FIFO is never issued. A same-cycle write into an empty FIFO becomes visible the next cycle.
- FSM states: IDLE, START, WAIT, GAP.
- IDLE: if FIFO not empty and !m_valid, pop the entry into core_msg/core_eORd. Then:
  - if data ≥ n_i: load the output register with {m_data=0, m_err=1} and stay in IDLE.
  - otherwise go to START.
- START: core_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - On core_finish=1: capture core_result into m_data, set m_err=0, m_valid=1, go to GAP.
  - Otherwise, if the counter equals TIMEOUT: set m_data=0, m_err=1, m_valid=1, go to GAP.
  - Otherwise increment the counter.
- GAP: count GAP cycles, then go to IDLE. A core_finish still high during GAP/IDLE is ignored.
- Output register: m_valid holds until m_valid && m_ready, then clears next cycle. m_data/m_err are stable while m_valid=1.
- core_msg/core_eORd hold their value from the pop until the next pop.
- Reset (reset=0 on any clock edge, including mid-WAIT):
  - FIFO emptied, state returns to IDLE, counters cleared.
  - All outputs go to 0: core_start, core_msg, core_eORd, m_data, m_err, m_valid.
  - s_ready goes to 1 the first cycle after reset is released.
  - Any in-flight core result is dropped.

## Timing
- Acceptance edge at T (FIFO empty, IDLE, !m_valid): pop at T+1, core_start high during cycle T+2.
- core_finish sampled high at edge F: m_valid=1 from F onward (one-cycle capture).
- Earliest next core_start is GAP+2 cycles after F (GAP cycles, IDLE pop, START).
- Range-error path: m_valid=1 the cycle after the pop, and core_start is never asserted.
- Back-to-back: with m_ready tied high, throughput is one message per (core latency + GAP + 3) cycles.
- Timeout: with core_finish stuck at 0, m_err=1 appears TIMEOUT+1 cycles after core_start.

## Structure
- Package rsa_pkg holds:
  - the FSM state enum (IDLE, START, WAIT, GAP)
  - the FIFO entry typedef {mode, data}
  - GAP and TIMEOUT defaults
- Sub-module rsa_sync_fifo: parameterised DEPTH/WIDTH, synchronous active-low reset, full/empty, pointers with an extra wrap bit. It is reusable on the output side of the core later.

## Test plan
- Core instantiated with e=13, d=37, n=187. Write s_data=77, s_mode=1 → core_start 2 cycles after acceptance, m_data=110, m_err=0.
- s_data=110, s_mode=0 → m_data=77.
- Burst 77, 73, 82, 69, 65 with s_valid held high → s_ready drops after 4 entries; five results in order; exactly GAP+2 cycles from each finish to the next start.
- s_data=200 with n=187 → m_err=1, m_data=0, no core_start pulse; the next byte 77 still yields 110.
- m_ready=0 for 50 cycles after the first result → m_valid and m_data stable; no new core_start until the result is accepted.
- core_finish forced to 0 → m_err=1 at TIMEOUT+1 cycles after core_start. Separately, assert reset during WAIT → all outputs 0, FIFO empty, and a subsequent 77 gives 110.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA message sequencer and its FIFO.
package rsa_pkg;

  localparam int DEF_GAP       = 2;
  localparam int DEF_TIMEOUT   = 1023;
  localparam int DEF_WIDTH_MSG = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic                     mode;
    logic [DEF_WIDTH_MSG-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rsa_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and show-ahead read data.
module rsa_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rsa_msg_sequencer.sv
// Feeds buffered message bytes to the RSA core one at a time and returns tagged results.
module rsa_msg_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH_N     = 8,
  parameter int WIDTH_MSG_I = DEF_WIDTH_MSG,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int GAP         = DEF_GAP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH_N-1:0]     n_i,
  input  logic [WIDTH_MSG_I-1:0] s_data,
  input  logic                   s_mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH_MSG_I-1:0] core_msg,
  output logic                   core_eORd,
  output logic                   core_start,
  input  logic [WIDTH_N-1:0]     core_result,
  input  logic                   core_finish,
  output logic [WIDTH_N-1:0]     m_data,
  output logic                   m_err,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int CMP_W = (WIDTH_N > WIDTH_MSG_I) ? WIDTH_N : WIDTH_MSG_I;

  typedef struct packed {
    logic                   mode;
    logic [WIDTH_MSG_I-1:0] data;
  } entry_t;

  state_t            state;
  entry_t            wr_entry;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              out_of_range;
  logic              running;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  // running keeps s_ready low until the first edge after reset is released.
  assign s_ready      = running && !fifo_full;
  assign wr_entry     = '{mode: s_mode, data: s_data};
  assign pop          = (state == ST_IDLE) && !fifo_empty && !m_valid;
  assign out_of_range = CMP_W'(head.data) >= CMP_W'(n_i);

  rsa_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_valid && s_ready),
    .push_data (wr_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      core_start <= 1'b0;
      core_msg   <= '0;
      core_eORd  <= 1'b0;
      m_data     <= '0;
      m_err      <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      running    <= 1'b1;
      core_start <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            core_msg  <= head.data;
            core_eORd <= head.mode;
            if (out_of_range) begin
              m_data  <= '0;
              m_err   <= 1'b1;
              m_valid <= 1'b1;
            end else begin
              state <= ST_START;
            end
          end
        end

        ST_START: begin
          core_start <= 1'b1;
          to_cnt     <= '0;
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (core_finish || to_cnt == TO_W'(TIMEOUT)) begin
            m_data  <= core_finish ? core_result : '0;
            m_err   <= !core_finish;
            m_valid <= 1'b1;
            gap_cnt <= '0;
            state   <= (GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP - 1)) state <= ST_IDLE;
          else                            gap_cnt <= gap_cnt + GAP_W'(1);
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
